// File: rtl/uart_pkt_pkg.sv
// uart_pkt_pkg: shared definitions for the UART packet framer.
//   pkt_state_t        - framer FSM state encoding
//   DEFAULT_SYNC_BYTE  - header byte sent ahead of every payload
package uart_pkt_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } pkt_state_t;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/uart_packet_tx.sv
// uart_packet_tx: frames a WORD_BYTES payload word as a byte stream for an
// external uart_tx_8n1: SYNC_BYTE, payload bytes (order set by LSB_FIRST),
// and, when macro UART_PKT_CHECKSUM_EN is defined, an XOR checksum byte.
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   synchronous active-high reset
//   in_data   in   payload word, 8*WORD_BYTES bits
//   in_valid  in   payload word offered
//   in_ready  out  block can accept a word (IDLE)
//   tx_byte   out  byte for the UART transmitter
//   tx_start  out  one-cycle start pulse for the UART transmitter
//   tx_busy   in   UART transmitter busy flag
//   busy      out  packet in progress
//   pkt_done  out  one-cycle pulse after the final byte completes
module uart_packet_tx
    import uart_pkt_pkg::*;
#(
    parameter int unsigned WORD_BYTES = 2,
    parameter logic [7:0]  SYNC_BYTE  = DEFAULT_SYNC_BYTE,
    parameter bit          LSB_FIRST  = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [8*WORD_BYTES-1:0] in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [7:0]              tx_byte,
    output logic                    tx_start,
    input  logic                    tx_busy,
    output logic                    busy,
    output logic                    pkt_done
);

`ifdef UART_PKT_CHECKSUM_EN
    localparam int unsigned FRAME_LEN = WORD_BYTES + 2;
`else
    localparam int unsigned FRAME_LEN = WORD_BYTES + 1;
`endif
    localparam int unsigned      IDX_W    = $clog2(WORD_BYTES + 3);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    pkt_state_t              r_state;
    logic [8*WORD_BYTES-1:0] r_word;
    logic [IDX_W-1:0]        r_idx;
    logic [7:0]              r_tx_byte;
    logic                    r_tx_start;
    logic                    r_pkt_done;

    logic [IDX_W-1:0]        w_next_idx;
    logic [7:0]              w_next_byte;

`ifdef UART_PKT_CHECKSUM_EN
    logic [7:0] w_csum;

    always_comb begin
        w_csum = '0;
        for (int unsigned i = 0; i < WORD_BYTES; i++) begin
            w_csum = w_csum ^ r_word[8*i +: 8];
        end
    end
`endif

    // Byte for the frame position following r_idx; index 0 is SYNC_BYTE,
    // 1..WORD_BYTES are payload, and the checksum (if any) is last.
    always_comb begin
        w_next_idx  = r_idx + 1'b1;
        w_next_byte = '0;
        for (int unsigned i = 0; i < WORD_BYTES; i++) begin
            if (w_next_idx == IDX_W'(i + 1)) begin
                w_next_byte = r_word[8*(LSB_FIRST ? i : WORD_BYTES - 1 - i) +: 8];
            end
        end
`ifdef UART_PKT_CHECKSUM_EN
        if (w_next_idx == LAST_IDX) begin
            w_next_byte = w_csum;
        end
`endif
    end

    // tx_start is registered, so it is set on the edge that enters LOAD and
    // is high during the LOAD cycle. If the transmitter is still draining on
    // entry, LOAD waits and raises tx_start once tx_busy has been seen low.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_word     <= '0;
            r_idx      <= '0;
            r_tx_byte  <= '0;
            r_tx_start <= 1'b0;
            r_pkt_done <= 1'b0;
        end else begin
            r_tx_start <= 1'b0;
            r_pkt_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_word     <= in_data;
                        r_idx      <= '0;
                        r_tx_byte  <= SYNC_BYTE;
                        r_tx_start <= !tx_busy;
                        r_state    <= LOAD;
                    end
                end
                LOAD: begin
                    if (r_tx_start) begin
                        r_state <= WAIT_ACK;
                    end else if (!tx_busy) begin
                        r_tx_start <= 1'b1;
                    end
                end
                WAIT_ACK: begin
                    if (tx_busy) begin
                        r_state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        if (r_idx == LAST_IDX) begin
                            r_pkt_done <= 1'b1;
                            r_state    <= IDLE;
                        end else begin
                            r_idx      <= w_next_idx;
                            r_tx_byte  <= w_next_byte;
                            r_tx_start <= 1'b1;
                            r_state    <= LOAD;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready = (r_state == IDLE);
    assign busy     = (r_state != IDLE);
    assign tx_byte  = r_tx_byte;
    assign tx_start = r_tx_start;
    assign pkt_done = r_pkt_done;

endmodule

// File: tb/tb_uart_packet_tx.sv
// tb_uart_packet_tx: directed bench for uart_packet_tx. Two instances:
// A (WORD_BYTES=2, LSB_FIRST=1) and B (WORD_BYTES=4, LSB_FIRST=0), each with
// a uart_tx_8n1 stand-in raising busy one cycle after start for 10 cycles.
// Expected checksum bytes apply when UART_PKT_CHECKSUM_EN is defined.
module tb_uart_packet_tx;

`ifdef UART_PKT_CHECKSUM_EN
    localparam int unsigned CKS = 1;
`else
    localparam int unsigned CKS = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [15:0] a_in_data = '0;
    logic        a_in_valid = 1'b0, a_in_ready, a_tx_start, a_tx_busy, a_busy, a_pkt_done;
    logic [7:0]  a_tx_byte;
    logic [31:0] b_in_data = '0;
    logic        b_in_valid = 1'b0, b_in_ready, b_tx_start, b_tx_busy, b_busy, b_pkt_done;
    logic [7:0]  b_tx_byte;

    uart_packet_tx #(.WORD_BYTES(2), .LSB_FIRST(1'b1)) u_a (
        .clk(clk), .rst(rst), .in_data(a_in_data), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .tx_byte(a_tx_byte), .tx_start(a_tx_start),
        .tx_busy(a_tx_busy), .busy(a_busy), .pkt_done(a_pkt_done));

    uart_packet_tx #(.WORD_BYTES(4), .LSB_FIRST(1'b0)) u_b (
        .clk(clk), .rst(rst), .in_data(b_in_data), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .tx_byte(b_tx_byte), .tx_start(b_tx_start),
        .tx_busy(b_tx_busy), .busy(b_busy), .pkt_done(b_pkt_done));

    // Transmitter stand-ins; a_force holds busy high to mimic a draining UART.
    int unsigned a_cnt = 0, b_cnt = 0;
    logic        a_force = 1'b0;
    always @(posedge clk) begin
        if (a_tx_start) a_cnt <= 10; else if (a_cnt != 0) a_cnt <= a_cnt - 1;
        if (b_tx_start) b_cnt <= 10; else if (b_cnt != 0) b_cnt <= b_cnt - 1;
    end
    assign a_tx_busy = (a_cnt != 0) || a_force;
    assign b_tx_busy = (b_cnt != 0);

    // Monitors
    logic [7:0]  a_q[$], b_q[$];
    int unsigned starts[2], dones[2], dups[2];
    always @(negedge clk) begin
        if (a_tx_start) begin a_q.push_back(a_tx_byte); starts[0]++; if (a_tx_busy) dups[0]++; end
        if (b_tx_start) begin b_q.push_back(b_tx_byte); starts[1]++; if (b_tx_busy) dups[1]++; end
        if (a_pkt_done) dones[0]++;
        if (b_pkt_done) dones[1]++;
    end

    int unsigned n_vec = 0, n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        for (int unsigned k = 0; k < n; k++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic sel, input logic v, input logic [31:0] d);
        if (sel == 1'b0) begin a_in_valid = v; a_in_data = d[15:0]; end
        else begin b_in_valid = v; b_in_data = d; end
    endtask

    task automatic clear_mon();
        a_q.delete(); b_q.delete();
        for (int i = 0; i < 2; i++) begin starts[i] = 0; dones[i] = 0; dups[i] = 0; end
    endtask

    function automatic logic [7:0] qbyte(input logic sel, input int unsigned idx);
        if (sel == 1'b0) return (idx < a_q.size()) ? a_q[idx] : 8'hxx;
        return (idx < b_q.size()) ? b_q[idx] : 8'hxx;
    endfunction

    task automatic wait_dones(input logic sel, input int unsigned target, input string name);
        for (int unsigned k = 0; k < 400 && dones[sel] < target; k++) tick(1);
        chk({name, " pkt_done seen"}, dones[sel], target);
    endtask

    // exp holds up to 6 bytes, byte 0 in bits 47:40; len excludes checksum.
    task automatic check_frame(input logic sel, input string name, input logic [47:0] exp,
                               input int unsigned len, input logic [7:0] cks,
                               input int unsigned off, input int unsigned ndone);
        int unsigned n;
        logic [7:0]  e;
        n = len + CKS;
        chk({name, " starts"}, starts[sel], off + n);
        for (int unsigned k = 0; k < n; k++) begin
            e = (k < len) ? exp[47 - 8*k -: 8] : cks;
            chk($sformatf("%s byte%0d", name, k), qbyte(sel, off + k), e);
        end
        chk({name, " dones"}, dones[sel], ndone);
        chk({name, " dup starts"}, dups[sel], 0);
        chk({name, " in_ready"}, (sel ? b_in_ready : a_in_ready), 1);
        chk({name, " busy"}, (sel ? b_busy : a_busy), 0);
    endtask

    task automatic run_pkt(input logic sel, input logic [31:0] d, input logic [47:0] exp,
                           input int unsigned len, input logic [7:0] cks, input string name);
        clear_mon();
        drive(sel, 1'b1, d);
        tick(1);
        drive(sel, 1'b0, d);
        chk({name, " first start"}, (sel ? b_tx_start : a_tx_start), 1);
        chk({name, " first byte"}, (sel ? b_tx_byte : a_tx_byte), 8'hA5);
        wait_dones(sel, 1, name);
        check_frame(sel, name, exp, len, cks, 0, 1);
        tick(3);
    endtask

    typedef struct {
        logic        sel;
        logic [31:0] data;
        int unsigned len;
        logic [47:0] exp;
        logic [7:0]  cks;
    } vec_t;

    vec_t vecs[6];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{1'b0, 32'h0000_1234, 3, 48'hA5_34_12_00_00_00, 8'h26};
        vecs[1] = '{1'b1, 32'hDEAD_BEEF, 5, 48'hA5_DE_AD_BE_EF_00, 8'h22};
        vecs[2] = '{1'b0, 32'h0000_00FF, 3, 48'hA5_FF_00_00_00_00, 8'hFF};
        vecs[3] = '{1'b0, 32'h0000_A5A5, 3, 48'hA5_A5_A5_00_00_00, 8'h00};
        vecs[4] = '{1'b1, 32'h0102_0304, 5, 48'hA5_01_02_03_04_00, 8'h04};
        vecs[5] = '{1'b1, 32'h0000_0080, 5, 48'hA5_00_00_00_80_00, 8'h80};

        clear_mon();
        rst = 1'b1;
        tick(2);
        chk("reset tx_start", a_tx_start, 0);
        chk("reset tx_byte", a_tx_byte, 8'h00);
        chk("reset busy", a_busy, 0);
        chk("reset pkt_done", a_pkt_done, 0);
        chk("reset in_ready", a_in_ready, 1);
        chk("reset B tx_byte", b_tx_byte, 8'h00);
        chk("reset B in_ready", b_in_ready, 1);
        rst = 1'b0;
        tick(2);

        for (int i = 0; i < 6; i++) begin
            run_pkt(vecs[i].sel, vecs[i].data, vecs[i].exp, vecs[i].len, vecs[i].cks,
                    $sformatf("vec%0d", i));
        end

        // Word changed and valid held high mid-packet
        clear_mon();
        drive(1'b0, 1'b1, 32'h1234);
        tick(1);
        drive(1'b0, 1'b1, 32'hFFFF);
        tick(1);
        chk("hold in_ready low", a_in_ready, 0);
        wait_dones(1'b0, 1, "hold pkt1");
        check_frame(1'b0, "hold pkt1", 48'hA5_34_12_00_00_00, 3, 8'h26, 0, 1);
        tick(1);
        chk("hold second accept start", a_tx_start, 1);
        chk("hold second accept byte", a_tx_byte, 8'hA5);
        chk("hold second in_ready", a_in_ready, 0);
        drive(1'b0, 1'b0, 32'h0);
        wait_dones(1'b0, 2, "hold pkt2");
        check_frame(1'b0, "hold pkt2", 48'hA5_FF_FF_00_00_00, 3, 8'h00, 3 + CKS, 2);
        tick(3);

        // Reset during WAIT_DONE of byte 1
        clear_mon();
        drive(1'b0, 1'b1, 32'h1234);
        tick(1);
        drive(1'b0, 1'b0, 32'h0);
        for (int unsigned k = 0; k < 100 && starts[0] < 2; k++) tick(1);
        chk("rst reached byte1", starts[0], 2);
        for (int unsigned k = 0; k < 20 && !a_tx_busy; k++) tick(1);
        tick(3);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("rst busy", a_busy, 0);
        chk("rst in_ready", a_in_ready, 1);
        tick(30);
        chk("rst no more starts", starts[0], 2);
        chk("rst no pkt_done", dones[0], 0);
        run_pkt(1'b0, 32'h00FF, 48'hA5_FF_00_00_00_00, 3, 8'hFF, "post-rst");

        // Transmitter still busy at accept time
        clear_mon();
        a_force = 1'b1;
        drive(1'b0, 1'b1, 32'h1234);
        tick(1);
        drive(1'b0, 1'b0, 32'h0);
        chk("drain busy", a_busy, 1);
        chk("drain in_ready", a_in_ready, 0);
        tick(5);
        chk("drain start held off", starts[0], 0);
        a_force = 1'b0;
        wait_dones(1'b0, 1, "drain");
        check_frame(1'b0, "drain", 48'hA5_34_12_00_00_00, 3, 8'h26, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
